demux32_04_reg: RTL

- Registered 1-to-5 distributor for 32-bit datapath values: steers one source word into one of five destination hold registers, chosen by a 3-bit select.
- Its select decoding matches the team's 5-input 32-bit datapath mux: `signal[2]` overrides, otherwise `signal[1:0]` picks 0..3.
- Each destination has a fresh/acknowledge handshake so downstream consumers know when a new word has arrived, plus sticky overrun detection.

---
 rtl/demux32_04_reg.sv | 88 ++++++++
 1 files changed

// File: rtl/demux32_04_reg.sv
// demux32_04_reg: registered 1-to-5 word distributor with per-destination
// fresh/ack handshake, write strobes and sticky overrun flags.
module demux32_04_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [2:0]        signal,
    input  logic [DATA_W-1:0] data_In,
    input  logic [4:0]        ack,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic [DATA_W-1:0] data_4,
    output logic [4:0]        fresh,
    output logic [4:0]        wr_pulse,
    output logic [4:0]        ovf,
    output logic              ovf_any
);

    localparam int unsigned NUM_DEST = 5;

    logic [NUM_DEST-1:0] dest_oh_c;
    logic [NUM_DEST-1:0] hit_c;
    logic [NUM_DEST-1:0] fresh_nxt_c;
    logic [NUM_DEST-1:0] ovf_set_c;
    logic [NUM_DEST-1:0] ovf_nxt_c;

    // Select decode: signal[2] forces destination 4, else signal[1:0] picks 0..3.
    always_comb begin
        dest_oh_c = '0;
        if (signal[2]) begin
            dest_oh_c[4] = 1'b1;
        end else begin
            case (signal[1:0])
                2'd0:    dest_oh_c[0] = 1'b1;
                2'd1:    dest_oh_c[1] = 1'b1;
                2'd2:    dest_oh_c[2] = 1'b1;
                default: dest_oh_c[3] = 1'b1;
            endcase
        end
    end

    // Per-destination next state: write sets fresh, ack clears it; an
    // unacknowledged write onto a fresh word is an overrun, and a set beats clr_ovf.
    always_comb begin
        hit_c       = write ? dest_oh_c : '0;
        fresh_nxt_c = (fresh & ~ack) | hit_c;
        ovf_set_c   = hit_c & fresh & ~ack;
        ovf_nxt_c   = (clr_ovf ? '0 : ovf) | ovf_set_c;
    end

    // Destination hold registers; only the targeted word is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_0 <= '0;
            data_1 <= '0;
            data_2 <= '0;
            data_3 <= '0;
            data_4 <= '0;
        end else begin
            if (hit_c[0]) data_0 <= data_In;
            if (hit_c[1]) data_1 <= data_In;
            if (hit_c[2]) data_2 <= data_In;
            if (hit_c[3]) data_3 <= data_In;
            if (hit_c[4]) data_4 <= data_In;
        end
    end

    // Handshake, strobe and overrun state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fresh    <= '0;
            wr_pulse <= '0;
            ovf      <= '0;
        end else begin
            fresh    <= fresh_nxt_c;
            wr_pulse <= hit_c;
            ovf      <= ovf_nxt_c;
        end
    end

    assign ovf_any = |ovf;

endmodule
